mxint8_block_sum: RTL and testbench

Registered reduction unit for one OCP MX MXINT8 block. It adds the 32 signed 8-bit elements exactly and applies the shared E8M0 scale. The result is emitted as an IEEE-754 binary32 value with overflow and NaN-scale flags. It sits in the MX ALU datapath between block unpacking and float32 accumulation/consumers, and is the block the mxint8_sum driver/monitor bench exercises.

---
 rtl/mxint8_block_sum.sv | 94 +++++++++
 tb/tb_mxint8_block_sum.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mxint8_block_sum.sv
// Exact sum of one MXINT8 block (32 x 1.6 fixed point) scaled by its E8M0 exponent,
// registered as an IEEE-754 binary32 value with overflow / NaN-scale flags.
module mxint8_block_sum #(
    parameter int unsigned BLOCK_SIZE    = 32,
    parameter int unsigned ELEMENT_WIDTH = 8,
    parameter int unsigned SCALE_WIDTH   = 8,
    parameter int unsigned FLOAT32_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SCALE_WIDTH-1:0]          i_scale,
    input  logic signed [ELEMENT_WIDTH-1:0] i_mxint8_elements [BLOCK_SIZE-1:0],
    output logic [FLOAT32_WIDTH-1:0]        o_float32,
    output logic                            o_overflow,
    output logic                            o_is_unused
);

    localparam int unsigned SUM_W = ELEMENT_WIDTH + $clog2(BLOCK_SIZE);

    localparam logic [FLOAT32_WIDTH-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FLOAT32_WIDTH-1:0] POS_INF = 32'h7F80_0000;

    logic signed [SUM_W-1:0]  sum_s;
    logic                     neg;
    logic [SUM_W-1:0]         mag;
    logic [3:0]               lead;
    logic signed [10:0]       exp_s;
    logic [22:0]              frac_norm;
    logic [22:0]              frac_sub;
    logic [4:0]               sub_sh;

    logic [FLOAT32_WIDTH-1:0] float_d, float_q;
    logic                     ovf_d, ovf_q;
    logic                     unused_d, unused_q;

    always_comb begin
        sum_s = '0;
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            sum_s = sum_s + {{(SUM_W-ELEMENT_WIDTH){i_mxint8_elements[i][ELEMENT_WIDTH-1]}},
                             i_mxint8_elements[i]};
        end

        neg = sum_s[SUM_W-1];
        mag = neg ? (~sum_s + 1'b1) : sum_s;

        lead = '0;
        for (int unsigned i = 0; i < SUM_W; i++) begin
            if (mag[i]) lead = 4'(i);
        end

        // E = p + scale - 6; 11 bits signed covers -6..260 without wrap
        exp_s = $signed({7'b0, lead}) + $signed({3'b0, i_scale}) - 11'sd6;

        // Shifting into a 23-bit field drops the implicit leading one
        frac_norm = 23'(mag) << (5'd23 - {1'b0, lead});
        // Only consulted when E <= 0, i.e. scale <= 6, so the 5-bit shift never wraps there
        sub_sh    = i_scale[4:0] + 5'd16;
        frac_sub  = 23'(mag) << sub_sh;

        float_d  = '0;
        ovf_d    = 1'b0;
        unused_d = 1'b0;
        if (i_scale == '1) begin
            float_d  = QNAN;
            unused_d = 1'b1;
        end else if (sum_s == '0) begin
            float_d = '0;
        end else if (exp_s >= 11'sd255) begin
            float_d = POS_INF | {neg, 31'b0};
            ovf_d   = 1'b1;
        end else if (exp_s >= 11'sd1) begin
            float_d = {neg, exp_s[7:0], frac_norm};
        end else begin
            float_d = {neg, 8'h00, frac_sub};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            float_q  <= '0;
            ovf_q    <= 1'b0;
            unused_q <= 1'b0;
        end else begin
            float_q  <= float_d;
            ovf_q    <= ovf_d;
            unused_q <= unused_d;
        end
    end

    assign o_float32   = float_q;
    assign o_overflow  = ovf_q;
    assign o_is_unused = unused_q;

endmodule

// File: tb/tb_mxint8_block_sum.sv
// Directed-vector bench for mxint8_block_sum: hand-computed binary32 results,
// one-cycle latency, reset behaviour and back-to-back streaming.
module tb_mxint8_block_sum;

    logic              clk;
    logic              rst_n;
    logic [7:0]        i_scale;
    logic signed [7:0] elems [31:0];
    logic [31:0]       o_float32;
    logic              o_overflow;
    logic              o_is_unused;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] prev_f;

    mxint8_block_sum #(
        .BLOCK_SIZE    (32),
        .ELEMENT_WIDTH (8),
        .SCALE_WIDTH   (8),
        .FLOAT32_WIDTH (32)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_scale           (i_scale),
        .i_mxint8_elements (elems),
        .o_float32         (o_float32),
        .o_overflow        (o_overflow),
        .o_is_unused       (o_is_unused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic fill(input logic signed [7:0] v);
        for (int k = 0; k < 32; k++) elems[k] = v;
    endtask

    // Inputs are already on the pins; confirm nothing leaks before the edge,
    // then check the registered result one edge later.
    task automatic run_vec(input string tag, input logic [7:0] scale,
                           input logic [31:0] ef, input logic eo, input logic eu);
        i_scale = scale;
        #2;
        check_eq({tag, "_pre"}, o_float32, prev_f);
        @(posedge clk);
        #1;
        check_eq({tag, "_f"},   o_float32, ef);
        check_eq({tag, "_ovf"}, {31'b0, o_overflow}, {31'b0, eo});
        check_eq({tag, "_nan"}, {31'b0, o_is_unused}, {31'b0, eu});
        prev_f = ef;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prev_f   = 32'h0;

        // Nonzero data during reset: reset must win
        rst_n   = 1'b0;
        i_scale = 8'd127;
        fill(8'sh40);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_f",   o_float32, 32'h0);
        check_eq("rst_ovf", {31'b0, o_overflow}, 32'h0);
        check_eq("rst_nan", {31'b0, o_is_unused}, 32'h0);
        rst_n = 1'b1;

        fill(8'sh40);
        run_vec("ones_s127", 8'd127, 32'h4200_0000, 1'b0, 1'b0);
        run_vec("ones_hold", 8'd127, 32'h4200_0000, 1'b0, 1'b0);

        fill(8'sh80);
        run_vec("m2_s127", 8'd127, 32'hC280_0000, 1'b0, 1'b0);
        run_vec("m2_s254", 8'd254, 32'hFF80_0000, 1'b1, 1'b0);

        fill(8'sh7F);
        run_vec("nan_max", 8'hFF, 32'h7FC0_0000, 1'b0, 1'b1);
        run_vec("max_s254", 8'd254, 32'h7F80_0000, 1'b1, 1'b0);
        run_vec("max_s248", 8'd248, 32'h7EFE_0000, 1'b0, 1'b0);

        fill(8'sh00);
        elems[0] = 8'sh01;
        run_vec("lsb_s0", 8'd0, 32'h0001_0000, 1'b0, 1'b0);
        run_vec("lsb_s6", 8'd6, 32'h0040_0000, 1'b0, 1'b0);
        run_vec("lsb_s7", 8'd7, 32'h0080_0000, 1'b0, 1'b0);

        elems[1] = 8'sh02;
        run_vec("three_s2", 8'd2, 32'h000C_0000, 1'b0, 1'b0);

        fill(8'sh00);
        elems[5] = 8'shFF;
        run_vec("neg1_s0", 8'd0, 32'h8001_0000, 1'b0, 1'b0);
        run_vec("nan_neg", 8'hFF, 32'h7FC0_0000, 1'b0, 1'b1);

        for (int k = 0; k < 32; k++) elems[k] = (k < 16) ? 8'sh40 : 8'shC0;
        run_vec("cancel", 8'd127, 32'h0000_0000, 1'b0, 1'b0);

        for (int k = 0; k < 32; k++) elems[k] = 8'(k) - 8'sd16;
        run_vec("ramp", 8'd127, 32'hBE80_0000, 1'b0, 1'b0);

        // Mid-stream reset with live data on the pins
        fill(8'sh7F);
        i_scale = 8'd254;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_f",   o_float32, 32'h0);
        check_eq("mid_rst_ovf", {31'b0, o_overflow}, 32'h0);
        check_eq("mid_rst_nan", {31'b0, o_is_unused}, 32'h0);
        prev_f = 32'h0;
        rst_n  = 1'b1;

        // Back-to-back distinct blocks after reset release
        run_vec("b2b_0", 8'd248, 32'h7EFE_0000, 1'b0, 1'b0);
        fill(8'sh40);
        run_vec("b2b_1", 8'd127, 32'h4200_0000, 1'b0, 1'b0);
        fill(8'sh80);
        run_vec("b2b_2", 8'd127, 32'hC280_0000, 1'b0, 1'b0);
        run_vec("b2b_3", 8'hFF, 32'h7FC0_0000, 1'b0, 1'b1);
        fill(8'sh00);
        elems[31] = 8'sh01;
        run_vec("b2b_4", 8'd6, 32'h0040_0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
